// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: channel state encoding,
// default PWM resolution and a helper that classifies a channel's state.
package led_fade_pkg;

  localparam int PWM_BITS_DEFAULT = 8;
  localparam int PWM_MAX_DEFAULT  = (1 << PWM_BITS_DEFAULT) - 1;

  // Per-channel ramp state, derived each cycle from level vs. target
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RISE = 2'd1,
    CH_FALL = 2'd2
  } chan_state_e;

  // Map the level/target comparison onto a channel state
  function automatic chan_state_e classify(input logic at_target, input logic target_above);
    if (at_target) begin
      return CH_IDLE;
    end
    return target_above ? CH_RISE : CH_FALL;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register, ramp FSM, optional gamma
// stage and the PWM comparator that drives the pin register.
// Build option: LED_FADE_GAMMA_EN selects a squared brightness curve with
// one extra register stage on duty.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                fade_en,
  input  logic                step_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                active
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] duty;
  chan_state_e         state;

  // Target brightness and ramp direction from the current request
  always_comb begin
    target = req ? PWM_MAX : '0;
    state  = classify(level_reg == target, target > level_reg);
  end

  assign active = (state != CH_IDLE);

  // Next level: snap when fading is off, otherwise one step per tick.
  // The state already guarantees no step past either endpoint.
  always_comb begin
    level_next = level_reg;
    if (!fade_en) begin
      level_next = target;
    end else if (step_tick) begin
      case (state)
        CH_RISE: level_next = level_reg + 1'b1;
        CH_FALL: level_next = level_reg - 1'b1;
        default: level_next = level_reg;
      endcase
    end
  end

  // Brightness level register
  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  logic [PWM_BITS-1:0]   gamma_val;
  logic [PWM_BITS-1:0]   duty_reg;

  // Squared curve keeps full scale exactly at full scale so "on" stays solid
  always_comb begin
    level_sq  = {{PWM_BITS{1'b0}}, level_reg} * {{PWM_BITS{1'b0}}, level_reg};
    gamma_val = (level_reg == PWM_MAX) ? PWM_MAX : PWM_BITS'(level_sq >> PWM_BITS);
  end

  // Pipeline register on the gamma-mapped duty
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_reg <= '0;
    end else begin
      duty_reg <= gamma_val;
    end
  end

  assign duty = duty_reg;
`else
  assign duty = level_reg;
`endif

  // PWM comparator into the pin register; duty=PWM_MAX beats every count
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 1'b0;
    end else begin
      led <= (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: turns the PIO LED request word into per-LED PWM drive
// with smooth on/off ramps. Holds the shared step prescaler, the shared
// PWM counter and the busy reduction; one led_fade_channel per LED.
// Build option: LED_FADE_GAMMA_EN (gamma-mapped duty, see led_fade_channel).
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = PWM_BITS_DEFAULT,
  parameter int STEP_DIV = 98039   // clk cycles per fade step, must be >= 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_req,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int                  DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_RELOAD = DIV_W'(STEP_DIV - 1);
  // PWM counter runs 0..PWM_MAX-1 so a full-scale duty never sees a low slot
  localparam logic [PWM_BITS-1:0] PWM_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [DIV_W-1:0]    presc_reg;
  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [NUM_LEDS-1:0] active;
  logic                busy_reg;

  assign step_tick = (presc_reg == '0);

  // Step prescaler: down-counter, reloads after hitting zero
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= DIV_RELOAD;
    end else if (step_tick) begin
      presc_reg <= DIV_RELOAD;
    end else begin
      presc_reg <= presc_reg - 1'b1;
    end
  end

  // Shared PWM phase counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_reg <= '0;
    end else if (pwm_cnt_reg == PWM_LAST) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      led_fade_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .req       (led_req[gi]),
        .fade_en   (fade_en),
        .step_tick (step_tick),
        .pwm_cnt   (pwm_cnt_reg),
        .led       (led_out[gi]),
        .active    (active[gi])
      );
    end
  endgenerate

  // Busy flag: any channel not yet at its target
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= |active;
    end
  end

  assign busy = busy_reg;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with a behavioural brightness
// model and directed scenarios: reset, snap, full ramp, reversal.
module tb_led_fade_driver;

  localparam int NUM_LEDS = 10;
  localparam int PWM_BITS = 8;
  localparam int PWM_MAX  = 255;
  localparam int STEP_DIV = 4;
`ifdef LED_FADE_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                fade_en = 1'b1;
  logic [NUM_LEDS-1:0] led_req = '0;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (PWM_BITS),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .led_req (led_req),
    .fade_en (fade_en),
    .led_out (led_out),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Brightness per LED as integers; steps happen every STEP_DIV-th cycle
  // counted from reset release, PWM phase is the cycle count mod PWM_MAX.
  int                  m_level [NUM_LEDS];
  int                  m_gamma [NUM_LEDS];
  int                  m_n;
  logic [NUM_LEDS-1:0] exp_led;
  logic                exp_busy;
  logic                model_live = 1'b0;

  function automatic int gamma_of(input int l);
    if (l == PWM_MAX) return PWM_MAX;
    return (l * l) / (PWM_MAX + 1);
  endfunction

  function automatic int duty_of(input int i);
`ifdef LED_FADE_GAMMA_EN
    return m_gamma[i];
`else
    return m_level[i];
`endif
  endfunction

  function automatic int target_of(input int i);
    return led_req[i] ? PWM_MAX : 0;
  endfunction

  function automatic int move_toward(input int lvl, input int tgt);
    if (!fade_en) return tgt;
    if ((m_n % STEP_DIV) != STEP_DIV - 1) return lvl;
    if (tgt > lvl) return lvl + 1;
    if (tgt < lvl) return lvl - 1;
    return lvl;
  endfunction

  function automatic logic any_off_target();
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (m_level[i] != target_of(i)) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    model_live <= 1'b1;
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        m_level[i] <= 0;
        m_gamma[i] <= 0;
      end
      m_n      <= 0;
      exp_led  <= '0;
      exp_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        exp_led[i] <= (duty_of(i) > (m_n % PWM_MAX));
        m_gamma[i] <= gamma_of(m_level[i]);
        m_level[i] <= move_toward(m_level[i], target_of(i));
      end
      exp_busy <= any_off_target();
      m_n      <= m_n + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_live) begin
      check("cyc_led_out", 32'(led_out), 32'(exp_led));
      check("cyc_busy", 32'(busy), 32'(exp_busy));
    end
  end

  // Wait (bounded) until the model's channel reaches a level
  task automatic wait_level(input int ch, input int val, input int budget, input string name);
    int k = 0;
    while (m_level[ch] != val && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(m_level[ch]), 32'(val));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int cycles;
    int max_lvl;

    // Reset held with all LEDs requested
    reset   = 1'b1;
    led_req = 10'h3FF;
    fade_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_led_out", 32'(led_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("release_busy", 32'(busy), 32'd1);

    // Reset mid-ramp at level 50
    wait_level(0, 50, 400, "ramp_to_50");
    reset = 1'b1;
    @(negedge clk);
    check("midrst_led_out", 32'(led_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_model_level", 32'(m_level[0]), 32'd0);

    // Snap mode
    fade_en = 1'b0;
    led_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    led_req = 10'h001;
    @(negedge clk);
    check("snap_model_level", 32'(m_level[0]), 32'd255);
    check("snap_led_early", 32'(led_out[0]), 32'd0);
    repeat (LAT) @(negedge clk);
    ones = 0;
    for (int k = 0; k < PWM_MAX; k++) begin
      ones += int'(led_out[0]);
      @(negedge clk);
    end
    check("snap_full_duty", 32'(ones), 32'd255);
    led_req = '0;
    @(negedge clk);
    check("snap_off_hold", 32'(led_out[0]), 32'd1);
    repeat (LAT) @(negedge clk);
    check("snap_off", 32'(led_out[0]), 32'd0);
    repeat (3) @(negedge clk);

    // Full ramp on LED 9
    fade_en = 1'b1;
    led_req = 10'h200;
    @(negedge clk);
    check("ramp_busy_rise", 32'(busy), 32'd1);
    cycles = 1;
    while (busy && cycles < 1100) begin
      @(negedge clk);
      cycles++;
    end
    check("ramp_len_in_window", 32'(cycles >= 1016 && cycles <= 1024), 32'd1);
    check("ramp_model_top", 32'(m_level[9]), 32'd255);

    // Reversal on LED 3 at level 100
    led_req = 10'h208;
    wait_level(3, 100, 500, "rev_reach_100");
    led_req = 10'h200;
    cycles = 0;
    while (m_level[3] == 100 && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    check("rev_first_step", 32'(m_level[3]), 32'd99);
    max_lvl = 0;
    cycles = 0;
    while (m_level[3] != 0 && cycles < 500) begin
      if (m_level[3] > max_lvl) max_lvl = m_level[3];
      @(negedge clk);
      cycles++;
    end
    check("rev_reach_zero", 32'(m_level[3]), 32'd0);
    check("rev_never_above_100", 32'(max_lvl <= 100), 32'd1);
    repeat (2) @(negedge clk);
    check("rev_busy_low", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
